// File: rtl/adc_seg_fmt_pkg.sv
// rtl/adc_seg_fmt_pkg.sv - shared FSM state, glyph codes and digit width for adc_seg_fmt
package adc_seg_fmt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_FMT  = 2'd2
    } state_t;

    localparam int          DIGIT_W        = 4;
    localparam logic [3:0]  HEAD_CODE_DEF  = 4'd15;
    localparam logic [3:0]  BLANK_CODE_DEF = 4'd10;

endpackage

// File: rtl/adc_seg_fmt_bcd_dd_step.sv
// rtl/adc_seg_fmt_bcd_dd_step.sv - iterative double dabble, 8-bit binary to 3 BCD digits
module bcd_dd_step
    import adc_seg_fmt_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [7:0]           load_val,
    input  logic                 en,
    output logic [3*DIGIT_W-1:0] bcd
);

    logic [3*DIGIT_W-1:0] bcd_q;
    logic [7:0]           bin_q;
    logic [3*DIGIT_W-1:0] adj;

    // Add-3 correction is applied before the shift so that digits >= 5 carry.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*DIGIT_W +: DIGIT_W] >= 4'd5)
                adj[i*DIGIT_W +: DIGIT_W] = bcd_q[i*DIGIT_W +: DIGIT_W] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q <= '0;
            bin_q <= '0;
        end else if (load) begin
            bcd_q <= '0;
            bin_q <= load_val;
        end else if (en) begin
            {bcd_q, bin_q} <= {adj, bin_q} << 1;
        end
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/adc_seg_fmt.sv
// rtl/adc_seg_fmt.sv - averages ADC samples and formats the mean as segment glyph codes
module adc_seg_fmt
    import adc_seg_fmt_pkg::*;
#(
    parameter int         AVG_LOG2   = 2,
    parameter logic [3:0] HEAD_CODE  = HEAD_CODE_DEF,
    parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  din,
    input  logic        din_vld,
    output logic        busy,
    output logic [31:0] seg_val,
    output logic        seg_val_vld
);

    localparam int ACC_W = 8 + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int N     = 1 << AVG_LOG2;

    state_t               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_sum;
    logic [CNT_W-1:0]     cnt_q;
    logic [2:0]           conv_cnt_q;
    logic                 seg_load_q;
    logic                 accept, last;
    logic [3*DIGIT_W-1:0] bcd;
    logic [3:0]           h_code, t_code;

    assign accept  = din_vld && (state_q == ST_IDLE);
    assign last    = (cnt_q == CNT_W'(N - 1));
    assign acc_sum = acc_q + ACC_W'(din);
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && last) state_d = ST_CONV;
            ST_CONV: if (conv_cnt_q == 3'd7) state_d = ST_FMT;
            ST_FMT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            conv_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                acc_q <= last ? '0 : acc_sum;
                cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
            end
            if (state_q == ST_CONV)
                conv_cnt_q <= conv_cnt_q + 3'd1;
        end
    end

    // The mean is latched straight into the converter's binary register.
    bcd_dd_step u_dd (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .load     (accept && last),
        .load_val (acc_sum[AVG_LOG2 +: 8]),
        .en       (state_q == ST_CONV),
        .bcd      (bcd)
    );

    assign h_code = (bcd[11:8] == 4'd0) ? BLANK_CODE : bcd[11:8];
    assign t_code = (bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0) ? BLANK_CODE : bcd[7:4];

    // BCD stays stable after FMT until the next group loads, so the output
    // register one cycle later still sees the finished digits.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            seg_load_q  <= 1'b0;
            seg_val_vld <= 1'b0;
            seg_val     <= {HEAD_CODE, {7{BLANK_CODE}}};
        end else begin
            seg_load_q  <= (state_q == ST_FMT);
            seg_val_vld <= seg_load_q;
            if (seg_load_q)
                seg_val <= {HEAD_CODE, {4{BLANK_CODE}}, h_code, t_code, bcd[3:0]};
        end
    end

endmodule

// File: tb/tb_adc_seg_fmt.sv
// tb/tb_adc_seg_fmt.sv - self-checking bench for adc_seg_fmt at AVG_LOG2 = 0, 2 and 3
module tb_adc_seg_fmt;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic [7:0]  din       = 8'd0;
    logic        din_vld   = 1'b0;
    logic        busy_w [3];
    logic        vld_w  [3];
    logic [31:0] seg_w  [3];

    localparam logic [31:0] RST_WORD = 32'hFAAAAAAA;

    always #5 sys_clk = ~sys_clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        adc_seg_fmt #(.AVG_LOG2(g == 0 ? 0 : (g == 1 ? 2 : 3))) dut (
            .sys_clk     (sys_clk),
            .sys_rst_n   (sys_rst_n),
            .din         (din),
            .din_vld     (din_vld),
            .busy        (busy_w[g]),
            .seg_val     (seg_w[g]),
            .seg_val_vld (vld_w[g])
        );
    end

    int checks = 0;
    int errors = 0;
    bit go     = 0;

    function automatic int lg(int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    function automatic logic [31:0] fmt_word(int v);
        int h = v / 100;
        int t = (v / 10) % 10;
        int u = v % 10;
        logic [3:0] hc, tc;
        hc = (h == 0) ? 4'hA : 4'(h);
        tc = (h == 0 && t == 0) ? 4'hA : 4'(t);
        return {4'hF, 16'hAAAA, hc, tc, 4'(u)};
    endfunction

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h want %h", nm, k, act, exp);
        end
    endtask

    // Reference model: samples per group, result due 10 edges after the
    // accepting edge, input locked out for the next 9 edges.
    int          cyc = 0;
    int          sum_m [3], cnt_m [3], lock_m [3], due_m [3];
    logic [31:0] dval_m [3], seg_m [3];
    bit          vld_m [3];

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < 3; k++) begin
                sum_m[k] = 0; cnt_m[k] = 0; lock_m[k] = 0; due_m[k] = -1;
                dval_m[k] = RST_WORD; seg_m[k] = RST_WORD; vld_m[k] = 0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 3; k++) begin
                vld_m[k] = 0;
                if (due_m[k] == cyc) begin
                    seg_m[k] = dval_m[k]; vld_m[k] = 1; due_m[k] = -1;
                end
                if (lock_m[k] > 0) lock_m[k]--;
                else if (din_vld) begin
                    sum_m[k] += int'(din);
                    cnt_m[k]++;
                    if (cnt_m[k] == (1 << lg(k))) begin
                        dval_m[k] = fmt_word(sum_m[k] >> lg(k));
                        due_m[k]  = cyc + 10;
                        lock_m[k] = 9;
                        sum_m[k]  = 0;
                        cnt_m[k]  = 0;
                    end
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        if (go) begin
            for (int k = 0; k < 3; k++) begin
                chk("busy", k, 32'(busy_w[k]), 32'(lock_m[k] > 0));
                chk("vld",  k, 32'(vld_w[k]),  32'(vld_m[k]));
                chk("seg",  k, seg_w[k], seg_m[k]);
            end
        end
    end

    task automatic send(input logic [7:0] v);
        @(negedge sys_clk);
        din = v; din_vld = 1'b1;
        @(negedge sys_clk);
        din_vld = 1'b0;
    endtask

    task automatic wait_vld(input int k, input logic [31:0] exp, input string nm);
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge sys_clk);
            if (vld_w[k]) begin
                seen = 1;
                chk(nm, k, seg_w[k], exp);
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s[%0d] timeout got no vld want %h", nm, k, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
    endtask

    initial begin
        int nv, nb;
        #1 sys_rst_n = 1'b0;
        #20;
        go = 1;
        chk("rst_seg", 0, seg_w[0], RST_WORD);
        chk("rst_busy", 0, 32'(busy_w[0]), 32'd0);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;

        send(8'd7);   wait_vld(0, 32'hFAAAAAA7, "d7");
        send(8'd0);   wait_vld(0, 32'hFAAAAAA0, "d0");
        send(8'd10);  wait_vld(0, 32'hFAAAAA10, "d10");
        send(8'd255); wait_vld(0, 32'hFAAAA255, "d255");

        do_reset();
        send(8'd100); send(8'd101); send(8'd102);
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            nv += int'(vld_w[1]);
        end
        chk("no_vld_3", 1, 32'(nv), 32'd0);
        send(8'd104); wait_vld(1, 32'hFAAAA101, "mean101");

        do_reset();
        @(negedge sys_clk);
        din = 8'd50; din_vld = 1'b1;
        @(negedge sys_clk);
        nb = 0;
        for (int i = 0; i < 9; i++) begin
            nb += int'(busy_w[0]);
            @(negedge sys_clk);
        end
        din_vld = 1'b0;
        chk("busy_end", 0, 32'(busy_w[0]), 32'd0);
        chk("busy_len", 0, 32'(nb), 32'd9);
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge sys_clk);
            nv += int'(vld_w[0]);
        end
        chk("one_upd", 0, 32'(nv), 32'd1);
        chk("d50", 0, seg_w[0], 32'hFAAAAA50);

        do_reset();
        send(8'd123);
        repeat (3) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("mid_busy", 0, 32'(busy_w[0]), 32'd0);
        chk("mid_seg", 0, seg_w[0], RST_WORD);
        chk("mid_vld", 0, 32'(vld_w[0]), 32'd0);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        send(8'd9); wait_vld(0, 32'hFAAAAAA9, "d9");

        do_reset();
        repeat (8) send(8'd255);
        wait_vld(2, 32'hFAAAA255, "avg8_255");

        for (int i = 0; i < 3000; i++) begin
            @(negedge sys_clk);
            din     = 8'($urandom);
            din_vld = ($urandom % 3) != 0;
            if ($urandom % 500 == 0) begin
                din_vld = 1'b0;
                #2 sys_rst_n = 1'b0;
                @(negedge sys_clk);
                #2 sys_rst_n = 1'b1;
            end
        end
        din_vld = 1'b0;
        repeat (12) @(negedge sys_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
